// File: rtl/alu_cmd_issuer.sv
// Command issuer for the 8-bit 4-op ALU: buffers requests, drives the ALU from registers, returns results.
// Optional result checker (rspErr port) enabled with `define ALU_RSP_CHECK_EN.
module alu_cmd_issuer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     cmdValid,
    output logic                     cmdReady,
    input  logic [1:0]               cmdOp,
    input  logic [WIDTH-1:0]         cmdA,
    input  logic [WIDTH-1:0]         cmdB,
    output logic [1:0]               aluOpCode,
    output logic [WIDTH-1:0]         aluInputA,
    output logic [WIDTH-1:0]         aluInputB,
    input  logic [WIDTH-1:0]         aluOut,
    output logic                     rspValid,
    input  logic                     rspReady,
    output logic [WIDTH-1:0]         rspData,
    output logic [1:0]               rspOp,
    output logic [$clog2(DEPTH):0]   count
`ifdef ALU_RSP_CHECK_EN
    ,
    output logic                     rspErr
`endif
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRIVE = 2'd1;
    localparam logic [1:0] S_RESP  = 2'd2;

    logic [1:0]        r_mem_op [DEPTH];
    logic [WIDTH-1:0]  r_mem_a  [DEPTH];
    logic [WIDTH-1:0]  r_mem_b  [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic              w_pop;
    logic              w_rsp_load;
    logic              w_rsp_clr;

    logic [1:0]        r_alu_op;
    logic [WIDTH-1:0]  r_alu_a;
    logic [WIDTH-1:0]  r_alu_b;
    logic              r_rsp_valid;
    logic [WIDTH-1:0]  r_rsp_data;
    logic [1:0]        r_rsp_op;

    logic              w_push;
    logic              w_empty;

    // Ready depends only on the registered occupancy, so a same-cycle pop never opens a full FIFO
    assign cmdReady = (r_count < CW'(DEPTH));
    assign w_push   = cmdValid & cmdReady;
    assign w_empty  = (r_count == '0);

    assign aluOpCode = r_alu_op;
    assign aluInputA = r_alu_a;
    assign aluInputB = r_alu_b;
    assign rspValid  = r_rsp_valid;
    assign rspData   = r_rsp_data;
    assign rspOp     = r_rsp_op;
    assign count     = r_count;

    // FIFO storage, no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_op[r_wr_ptr] <= cmdOp;
            r_mem_a[r_wr_ptr]  <= cmdA;
            r_mem_b[r_wr_ptr]  <= cmdB;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) r_state <= S_IDLE;
        else         r_state <= w_next_state;
    end

    // Next state and datapath strobes; pop only uses registered occupancy (no bypass)
    always_comb begin
        w_next_state = r_state;
        w_pop        = 1'b0;
        w_rsp_load   = 1'b0;
        w_rsp_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_next_state = S_DRIVE;
                end
            end
            S_DRIVE: begin
                w_rsp_load   = 1'b1;
                w_next_state = S_RESP;
            end
            S_RESP: begin
                if (r_rsp_valid && rspReady) begin
                    w_rsp_clr = 1'b1;
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_next_state = S_DRIVE;
                    end else begin
                        w_next_state = S_IDLE;
                    end
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ALU operand registers hold their last value until the next pop
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_alu_op <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
        end else if (w_pop) begin
            r_alu_op <= r_mem_op[r_rd_ptr];
            r_alu_a  <= r_mem_a[r_rd_ptr];
            r_alu_b  <= r_mem_b[r_rd_ptr];
        end
    end

    // Response capture
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_op    <= '0;
        end else if (w_rsp_load) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= aluOut;
            r_rsp_op    <= r_alu_op;
        end else if (w_rsp_clr) begin
            r_rsp_valid <= 1'b0;
        end
    end

`ifdef ALU_RSP_CHECK_EN
    logic [WIDTH-1:0] w_golden;
    logic             r_rsp_err;

    // Reference result for the operands currently driven to the ALU
    always_comb begin
        w_golden = '0;
        case (r_alu_op)
            2'd0:    w_golden = r_alu_a & r_alu_b;
            2'd1:    w_golden = r_alu_a | r_alu_b;
            2'd2:    w_golden = (32'(r_alu_b) >= 32'(WIDTH)) ? '0 : (r_alu_a << r_alu_b);
            default: w_golden = r_alu_a + r_alu_b;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)         r_rsp_err <= 1'b0;
        else if (w_rsp_load) r_rsp_err <= (aluOut != w_golden);
    end

    assign rspErr = r_rsp_err;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer: queue-based reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_alu_cmd_issuer;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } cmd_t;

    logic             clk = 1'b0;
    logic             resetN;
    logic             cmdValid;
    logic             cmdReady;
    logic [1:0]       cmdOp;
    logic [WIDTH-1:0] cmdA;
    logic [WIDTH-1:0] cmdB;
    logic [1:0]       aluOpCode;
    logic [WIDTH-1:0] aluInputA;
    logic [WIDTH-1:0] aluInputB;
    logic [WIDTH-1:0] aluOut;
    logic             rspValid;
    logic             rspReady;
    logic [WIDTH-1:0] rspData;
    logic [1:0]       rspOp;
    logic [$clog2(DEPTH):0] count;
`ifdef ALU_RSP_CHECK_EN
    logic             rspErr;
`endif
    logic             tb_fault = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    alu_cmd_issuer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .resetN(resetN),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp), .cmdA(cmdA), .cmdB(cmdB),
        .aluOpCode(aluOpCode), .aluInputA(aluInputA), .aluInputB(aluInputB), .aluOut(aluOut),
        .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData), .rspOp(rspOp),
        .count(count)
`ifdef ALU_RSP_CHECK_EN
        , .rspErr(rspErr)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] alu_fn(input logic [1:0] op, input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return (int'(b) >= WIDTH) ? '0 : WIDTH'(a << b);
            default: return WIDTH'(a + b);
        endcase
    endfunction

    // Combinational ALU the block drives; tb_fault forces a wrong result
    always_comb aluOut = tb_fault ? '0 : alu_fn(aluOpCode, aluInputA, aluInputB);

    task automatic check(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending commands, the command at the ALU, and the held response
    cmd_t             mq[$];
    int               m_stage;
    logic [1:0]       m_alu_op;
    logic [WIDTH-1:0] m_alu_a, m_alu_b;
    logic             m_rsp_valid;
    logic [WIDTH-1:0] m_rsp_data;
    logic [1:0]       m_rsp_op;
    logic             m_rsp_err;
    logic [WIDTH-1:0] got[$];
    int               got_cyc[$];
    bit               m_push, m_pop;
    cmd_t             m_c;

    always @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            mq.delete();
            m_stage = 0;
            m_alu_op = '0; m_alu_a = '0; m_alu_b = '0;
            m_rsp_valid = 1'b0; m_rsp_data = '0; m_rsp_op = '0; m_rsp_err = 1'b0;
        end else begin
            cyc++;
            m_push = cmdValid && (mq.size() < DEPTH);
            m_pop  = 1'b0;
            if (m_stage == 0) begin
                if (mq.size() > 0) begin m_pop = 1'b1; m_stage = 1; end
            end else if (m_stage == 1) begin
                m_rsp_valid = 1'b1;
                m_rsp_data  = tb_fault ? '0 : alu_fn(m_alu_op, m_alu_a, m_alu_b);
                m_rsp_err   = (m_rsp_data != alu_fn(m_alu_op, m_alu_a, m_alu_b));
                m_rsp_op    = m_alu_op;
                m_stage     = 2;
            end else if (m_rsp_valid && rspReady) begin
                got.push_back(rspData);
                got_cyc.push_back(cyc);
                m_rsp_valid = 1'b0;
                if (mq.size() > 0) begin m_pop = 1'b1; m_stage = 1; end
                else m_stage = 0;
            end
            if (m_pop) begin
                m_c = mq.pop_front();
                m_alu_op = m_c.op; m_alu_a = m_c.a; m_alu_b = m_c.b;
            end
            if (m_push) begin
                m_c.op = cmdOp; m_c.a = cmdA; m_c.b = cmdB;
                mq.push_back(m_c);
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (resetN) begin
            check("cmdReady", cmdReady, longint'(mq.size() < DEPTH));
            check("count", count, mq.size());
            check("aluOpCode", aluOpCode, m_alu_op);
            check("aluInputA", aluInputA, m_alu_a);
            check("aluInputB", aluInputB, m_alu_b);
            check("rspValid", rspValid, m_rsp_valid);
            if (m_rsp_valid) begin
                check("rspData", rspData, m_rsp_data);
                check("rspOp", rspOp, m_rsp_op);
`ifdef ALU_RSP_CHECK_EN
                check("rspErr", rspErr, m_rsp_err);
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int n;
        cmdValid = 1'b1; cmdOp = op; cmdA = a; cmdB = b;
        n = 0;
        while (!cmdReady && n < 200) begin tick(); n++; end
        if (n >= 200) check("push_timeout", 1, 0);
        tick();
        cmdValid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((mq.size() != 0 || m_stage != 0) && n < 200) begin tick(); n++; end
        if (n >= 200) check("idle_timeout", 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] exp4[4];
        logic [WIDTH-1:0] exp5[5];
        resetN = 1'b0; cmdValid = 1'b0; cmdOp = '0; cmdA = '0; cmdB = '0; rspReady = 1'b1;
        tick(); tick();
        check("rst_count", count, 0);
        check("rst_rspValid", rspValid, 0);
        check("rst_aluInputA", aluInputA, 0);
        resetN = 1'b1;
        tick();
        check("rst_cmdReady", cmdReady, 1);

        // Single add: latency k+1 to ALU, k+2 to response
        push(2'd3, 8'h7F, 8'h01);
        check("t1_aluInputA_pre", aluInputA, 0);
        tick();
        check("t1_aluInputA", aluInputA, 8'h7F);
        tick();
        check("t1_rspValid", rspValid, 1);
        check("t1_rspData", rspData, 8'h80);
        check("t1_rspOp", rspOp, 3);
        wait_idle();

        // Back-to-back stream with the consumer always ready
        got.delete(); got_cyc.delete();
        push(2'd0, 8'hF0, 8'h3C);
        push(2'd1, 8'hF0, 8'h0F);
        push(2'd2, 8'h01, 8'h03);
        push(2'd3, 8'hFF, 8'h02);
        wait_idle();
        exp4[0] = 8'h30; exp4[1] = 8'hFF; exp4[2] = 8'h08; exp4[3] = 8'h01;
        check("t2_nrsp", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) check($sformatf("t2_rsp%0d", i), got[i], exp4[i]);
        for (int i = 1; i < 4 && i < got_cyc.size(); i++)
            check($sformatf("t2_gap%0d", i), got_cyc[i] - got_cyc[i-1], 2);

        // Backpressure: one response held plus a full FIFO
        got.delete();
        rspReady = 1'b0;
        push(2'd3, 8'h01, 8'h02);
        push(2'd0, 8'hFF, 8'h0F);
        push(2'd1, 8'h10, 8'h01);
        push(2'd2, 8'h01, 8'h04);
        push(2'd3, 8'h80, 8'h80);
        tick();
        check("t3_count_full", count, 4);
        check("t3_cmdReady_full", cmdReady, 0);
        check("t3_rspValid_held", rspValid, 1);
        check("t3_rspData_held", rspData, 8'h03);
        rspReady = 1'b1;
        wait_idle();
        exp5[0] = 8'h03; exp5[1] = 8'h0F; exp5[2] = 8'h11; exp5[3] = 8'h10; exp5[4] = 8'h00;
        check("t3_nrsp", got.size(), 5);
        for (int i = 0; i < 5 && i < got.size(); i++) check($sformatf("t3_rsp%0d", i), got[i], exp5[i]);
        check("t3_cmdReady_after", cmdReady, 1);

        // Shift boundary around WIDTH
        got.delete();
        push(2'd2, 8'h81, 8'h07);
        push(2'd2, 8'h81, 8'h09);
        push(2'd2, 8'h81, 8'h08);
        wait_idle();
        check("t4_nrsp", got.size(), 3);
        if (got.size() == 3) begin
            check("t4_shl7", got[0], 8'h80);
            check("t4_shl9", got[1], 8'h00);
            check("t4_shl8", got[2], 8'h00);
        end

        // Asynchronous reset while a response is held and two commands are queued
        got.delete();
        rspReady = 1'b0;
        push(2'd1, 8'h5A, 8'h21);
        push(2'd3, 8'h11, 8'h22);
        push(2'd0, 8'h33, 8'h44);
        tick();
        check("t5_pre_rspValid", rspValid, 1);
        check("t5_pre_count", count, 2);
        #2 resetN = 1'b0;
        #1;
        check("t5_rspValid", rspValid, 0);
        check("t5_count", count, 0);
        check("t5_aluOpCode", aluOpCode, 0);
        check("t5_aluInputA", aluInputA, 0);
        check("t5_aluInputB", aluInputB, 0);
        check("t5_rspData", rspData, 0);
        #3 resetN = 1'b1;
        rspReady = 1'b1;
        repeat (6) tick();
        check("t5_no_stale_rsp", got.size(), 0);
        check("t5_rspValid_after", rspValid, 0);
        check("t5_cmdReady_after", cmdReady, 1);

`ifdef ALU_RSP_CHECK_EN
        // Checker flags a corrupted ALU result and stays quiet otherwise
        got.delete();
        rspReady = 1'b0;
        tb_fault = 1'b1;
        push(2'd1, 8'h01, 8'h02);
        tick(); tick();
        check("t6_err_valid", rspValid, 1);
        check("t6_err_set", rspErr, 1);
        tb_fault = 1'b0;
        rspReady = 1'b1;
        wait_idle();
        rspReady = 1'b0;
        push(2'd1, 8'h01, 8'h02);
        tick(); tick();
        check("t6_ok_data", rspData, 8'h03);
        check("t6_err_clear", rspErr, 0);
        rspReady = 1'b1;
        wait_idle();
`endif

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator-side companion to the 8-bit 4-op ALU. It accepts operation requests over a valid/ready command port and buffers them in a small FIFO.
- It drives each buffered request onto the ALU's opCode/inputA/inputB from registers, then captures the ALU result one cycle later.
- It returns the result over a valid/ready response port. It sits between a host or test sequencer and the combinational ALU, and is the only driver of the ALU inputs.

Parameters:
- WIDTH, 8, operand and result width; must match the ALU width.
- DEPTH, 4, command FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- resetN  input  1  asynchronous, active-low reset.
- Interface: one clock; reset is asynchronous and active-low.
- cmdValid  input  1  command request valid.
- cmdReady  output  1  command FIFO can accept.
- cmdOp  input  2  0=AND, 1=OR, 2=shift-left A by B, 3=add.
- cmdA  input  WIDTH  operand A.
- cmdB  input  WIDTH  operand B.
- aluOpCode  output  2  registered opcode to the ALU.
- aluInputA  output  WIDTH  registered operand A to the ALU.
- aluInputB  output  WIDTH  registered operand B to the ALU.
- aluOut  input  WIDTH  ALU result, combinational from the three outputs above.
- rspValid  output  1  response valid.
- rspReady  input  1  response consumer ready.
- rspData  output  WIDTH  captured ALU result.
- rspOp  output  2  opcode that produced rspData.
- count  output  clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (resetN low, asynchronous): FIFO empty, count=0, state IDLE, aluOpCode/aluInputA/aluInputB=0, rspValid=0, rspData=0, rspOp=0.
  - A command or result in flight when reset asserts is discarded.
  - After release, cmdReady=1.
- Command accept: cmdValid & cmdReady at a rising edge pushes {cmdOp,cmdA,cmdB}.
  - cmdReady = (count < DEPTH), derived from registered count only.
  - When full, cmdReady=0 even if a pop occurs in the same cycle; no combinational ready path.
- FIFO: circular, read/write pointers wrap at DEPTH. A simultaneous push and pop leaves count unchanged. A push while full and a pop while empty must never occur.
- FSM states: IDLE, DRIVE, RESP.
  - IDLE: if FIFO non-empty, pop head into aluOpCode/aluInputA/aluInputB; go to DRIVE.
  - DRIVE: ALU inputs are stable for the full cycle. At the next edge, rspData<=aluOut, rspOp<=aluOpCode, rspValid<=1; go to RESP.
  - RESP: hold rspValid, rspData and rspOp stable until rspValid & rspReady.
    - On handshake with FIFO non-empty: pop the next entry into the ALU registers at the same edge; go to DRIVE; rspValid<=0.
    - On handshake with FIFO empty: go to IDLE; rspValid<=0.
- ALU inputs hold their last driven value outside DRIVE; they are not cleared.
- Latency: a command accepted at edge k into an empty, idle block drives the ALU after edge k+1 and gives rspValid=1 after edge k+2.
  - A command pushed into an empty FIFO is not popped at the same edge (no bypass).
- Throughput: one result per 2 cycles with rspReady held high.
- Ordering: responses return strictly in command order; none dropped or duplicated.
- Backpressure: rspReady low stalls the FSM in RESP. The FIFO keeps accepting until full.

Optional Feature:
- Macro ALU_RSP_CHECK_EN.
- Defined:
  - Adds output rspErr (1 bit, reset 0), updated with rspData.
  - An internal golden model computes the expected result from the popped command:
    - AND and OR bitwise.
    - Shift: A<<B, result 0 when B>=WIDTH.
    - Add modulo 2^WIDTH.
  - rspErr=1 when aluOut differs from the golden result. It is valid only while rspValid=1.
- Undefined: no rspErr port and no checker logic; all other behaviour is identical.

Test Plan:
- Reset then a single command op=3 A=0x7F B=0x01 with rspReady=1 -> aluInputA=0x7F after edge k+1; rspValid=1, rspData=0x80, rspOp=3 after edge k+2.
- Four back-to-back commands (0: 0xF0,0x3C; 1: 0xF0,0x0F; 2: 0x01,0x03; 3: 0xFF,0x02), rspReady=1 -> responses in order 0x30, 0xFF, 0x08, 0x01 (add wraps), one every 2 cycles.
- rspReady=0, push 5 commands with DEPTH=4 -> 1 in RESP plus 4 buffered; count=4, cmdReady=0. Raise rspReady -> all 5 responses returned in order; cmdReady rises once count<4.
- Shift boundary: op=2 A=0x81 B=0x07 -> 0x80; op=2 A=0x81 B=0x09 -> 0x00.
- Assert resetN low while in RESP with 2 entries queued -> rspValid=0, count=0, ALU inputs 0 immediately, no stale responses after release.
- With ALU_RSP_CHECK_EN, force aluOut to 0x00 for op=1 A=0x01 B=0x02 -> rspErr=1. Unforced -> rspErr=0.
